// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline definitions for the hazard controller.
// Holds the FSM state encoding, the divide latency default, the freeze
// counter width and a saturating increment helper for the stall counter.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_BUSY = 1'b1
  } hz_state_t;

  localparam int DIV_LATENCY_DEFAULT = 32;

  // Wide enough for the largest legal latency (63).
  localparam int CNT_W = 6;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == STALL_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_loaduse_detect.sv
// loaduse_detect: flags a load in EXE whose destination feeds a source
// register read by the instruction in ID. A load into x0 never creates a
// hazard because x0 is hard-wired to zero.
module loaduse_detect (
  input  logic       exe_is_load,
  input  logic       exe_wr_en,
  input  logic [4:0] exe_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  // Compare each live source operand against the load destination.
  always_comb begin
    rs1_hit = id_uses_rs1 & (id_rs1 == exe_rd);
    rs2_hit = id_uses_rs2 & (id_rs2 == exe_rd);
    lu      = exe_is_load & exe_wr_en & (exe_rd != 5'd0) & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller.
// Resolves, in priority order, the divide freeze, taken-branch flush and
// load-use bubble, and counts cycles in which fetch is held.
// Optional feature macro: PIPE_HAZARD_DIV_EN enables the iterative divider
// freeze (RUN/DIV_BUSY FSM, freeze counter, div_start and busy). Without it
// exe_is_div is ignored and div_start/busy are tied low.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  exe_rd,
  input  logic        exe_is_load,
  input  logic        exe_wr_en,
  input  logic        exe_is_div,
  input  logic        exe_branch_taken,
  output logic        if_id_en,
  output logic        if_id_flush,
  output logic        id_exe_en,
  output logic        id_exe_flush,
  output logic        exe_mem_en,
  output logic        div_start,
  output logic        busy,
  output logic [15:0] stall_cycles
);

  logic lu;
  logic div_take;

  loaduse_detect u_loaduse_detect (
    .exe_is_load (exe_is_load),
    .exe_wr_en   (exe_wr_en),
    .exe_rd      (exe_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .lu          (lu)
  );

`ifdef PIPE_HAZARD_DIV_EN
  // The start cycle is the first freeze cycle, so the counter covers the rest.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  hz_state_t        state;
  logic [CNT_W-1:0] div_cnt;
  logic             div_done;

  // div_done masks exe_is_div for one cycle so the finished divide can leave EXE.
  assign div_take = (state == RUN) & exe_is_div & ~div_done;
  assign busy     = (state == DIV_BUSY);

  // Divide freeze FSM: load the counter on start, count down, release at zero.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= RUN;
      div_cnt  <= '0;
      div_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          div_done <= 1'b0;
          if (div_take) begin
            div_cnt <= DIV_LOAD;
            state   <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          div_cnt <= div_cnt - 1'b1;
          if (div_cnt == CNT_W'(1)) begin
            state    <= RUN;
            div_done <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end
`else
  logic             div_in_unused;
  logic [CNT_W-1:0] div_cfg_unused;

  assign div_in_unused  = exe_is_div;
  assign div_cfg_unused = CNT_W'(DIV_LATENCY - 1);
  assign div_take       = 1'b0;
  assign busy           = 1'b0;
`endif

  // Mealy control outputs: reset and freeze hold everything, then branch beats load-use.
  always_comb begin
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_exe_en    = 1'b0;
    id_exe_flush = 1'b0;
    exe_mem_en   = 1'b0;
    div_start    = 1'b0;
    if (!nrst || busy) begin
      div_start = 1'b0;
    end else if (div_take) begin
      div_start = 1'b1;
    end else if (exe_branch_taken) begin
      if_id_en     = 1'b1;
      id_exe_en    = 1'b1;
      exe_mem_en   = 1'b1;
      if_id_flush  = 1'b1;
      id_exe_flush = 1'b1;
    end else if (lu) begin
      id_exe_en    = 1'b1;
      exe_mem_en   = 1'b1;
      id_exe_flush = 1'b1;
    end else begin
      if_id_en   = 1'b1;
      id_exe_en  = 1'b1;
      exe_mem_en = 1'b1;
    end
  end

  // Count every cycle in which fetch is held, saturating at the top.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      stall_cycles <= 16'd0;
    end else if (!if_id_en) begin
      stall_cycles <= sat_inc16(stall_cycles);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl with an
// abstract cycle model and per-cycle comparison of every output.
// Honours PIPE_HAZARD_DIV_EN in the same way as the design.
module tb_pipe_hazard_ctrl;

  localparam int L = 4;
`ifdef PIPE_HAZARD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [4:0]  id_rs1 = 5'd0;
  logic [4:0]  id_rs2 = 5'd0;
  logic        id_uses_rs1 = 1'b0;
  logic        id_uses_rs2 = 1'b0;
  logic [4:0]  exe_rd = 5'd0;
  logic        exe_is_load = 1'b0;
  logic        exe_wr_en = 1'b0;
  logic        exe_is_div = 1'b0;
  logic        exe_branch_taken = 1'b0;
  logic        if_id_en, if_id_flush, id_exe_en, id_exe_flush, exe_mem_en;
  logic        div_start, busy;
  logic [15:0] stall_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: remaining frozen cycles, release flag and stall tally.
  int freeze_left = 0;
  bit after_div = 1'b0;
  int stalls = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.DIV_LATENCY(L)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs1      (id_uses_rs1),
    .id_uses_rs2      (id_uses_rs2),
    .exe_rd           (exe_rd),
    .exe_is_load      (exe_is_load),
    .exe_wr_en        (exe_wr_en),
    .exe_is_div       (exe_is_div),
    .exe_branch_taken (exe_branch_taken),
    .if_id_en         (if_id_en),
    .if_id_flush      (if_id_flush),
    .id_exe_en        (id_exe_en),
    .id_exe_flush     (id_exe_flush),
    .exe_mem_en       (exe_mem_en),
    .div_start        (div_start),
    .busy             (busy),
    .stall_cycles     (stall_cycles)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic n, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic ld, input logic wr, input logic dv, input logic br);
    @(negedge clk);
    nrst             = n;
    id_rs1           = rs1;
    id_rs2           = rs2;
    id_uses_rs1      = u1;
    id_uses_rs2      = u2;
    exe_rd           = rd;
    exe_is_load      = ld;
    exe_wr_en        = wr;
    exe_is_div       = dv;
    exe_branch_taken = br;
  endtask

  task automatic idle(input logic n);
    applyStimulus(n, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic bit lu_model();
    if (!exe_is_load || !exe_wr_en || exe_rd == 5'd0) return 1'b0;
    return (id_uses_rs1 && id_rs1 == exe_rd) || (id_uses_rs2 && id_rs2 == exe_rd);
  endfunction

  // Compare process: predict every output from the model, then advance it.
  initial begin
    bit e_ifen, e_iff, e_idxen, e_idxf, e_mem, e_start, e_busy;
    forever begin
      @(negedge clk);
      #2;
      {e_ifen, e_iff, e_idxen, e_idxf, e_mem, e_start} = '0;
      e_busy = (freeze_left > 0);
      if (!nrst || freeze_left > 0) begin
        e_start = 1'b0;
      end else if (DIV_EN && exe_is_div && !after_div) begin
        e_start = 1'b1;
      end else if (exe_branch_taken) begin
        {e_ifen, e_iff, e_idxen, e_idxf, e_mem} = 5'b11111;
      end else if (lu_model()) begin
        {e_idxen, e_idxf, e_mem} = 3'b111;
      end else begin
        {e_ifen, e_idxen, e_mem} = 3'b111;
      end
      checkOutput("if_id_en", 32'(if_id_en), 32'(e_ifen));
      checkOutput("if_id_flush", 32'(if_id_flush), 32'(e_iff));
      checkOutput("id_exe_en", 32'(id_exe_en), 32'(e_idxen));
      checkOutput("id_exe_flush", 32'(id_exe_flush), 32'(e_idxf));
      checkOutput("exe_mem_en", 32'(exe_mem_en), 32'(e_mem));
      checkOutput("div_start", 32'(div_start), 32'(e_start));
      checkOutput("busy", 32'(busy), 32'(e_busy));
      checkOutput("stall_cycles", 32'(stall_cycles), 32'(stalls));
      @(posedge clk);
      if (!nrst) begin
        freeze_left = 0;
        after_div   = 1'b0;
        stalls      = 0;
      end else begin
        if (!e_ifen) stalls = (stalls < 65535) ? stalls + 1 : 65535;
        if (freeze_left > 0) begin
          freeze_left--;
          after_div = (freeze_left == 0);
        end else if (e_start) begin
          freeze_left = L - 1;
          after_div   = 1'b0;
        end else begin
          after_div = 1'b0;
        end
      end
    end
  end

  // Directed scenarios with hand-computed literal expectations.
  initial begin
    idle(1'b0);
    #3 checkOutput("reset_if_id_en", 32'(if_id_en), 32'd0);
    idle(1'b0);
    #3 checkOutput("reset_stall", 32'(stall_cycles), 32'd0);
    idle(1'b1);
    #3 checkOutput("run_if_id_en", 32'(if_id_en), 32'd1);

    // Load x5, ID add reads x5 through rs2.
    applyStimulus(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    #3 checkOutput("lu_if_id_en", 32'(if_id_en), 32'd0);
    checkOutput("lu_id_exe_flush", 32'(id_exe_flush), 32'd1);
    idle(1'b1);
    #3 checkOutput("lu_stall_count", 32'(stall_cycles), 32'd1);

    // Load x0 never stalls.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    #3 checkOutput("x0_if_id_en", 32'(if_id_en), 32'd1);

    // Non-hazard variants: not a load, no write, operand unused.
    applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd7, 5'd9, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    // rs1 hit.
    applyStimulus(1'b1, 5'd9, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);

    // Branch together with load-use: flush wins, nothing counted.
    applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    #3 checkOutput("br_if_id_flush", 32'(if_id_flush), 32'd1);
    checkOutput("br_id_exe_flush", 32'(id_exe_flush), 32'd1);
    checkOutput("br_if_id_en", 32'(if_id_en), 32'd1);
    idle(1'b1);
    #3 checkOutput("br_stall_count", 32'(stall_cycles), 32'd2);

    // Divide held in EXE for five cycles.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef PIPE_HAZARD_DIV_EN
    #3 checkOutput("div_start_pulse", 32'(div_start), 32'd1);
    checkOutput("div_start_freeze", 32'(if_id_en), 32'd0);
`else
    #3 checkOutput("div_ignored_start", 32'(div_start), 32'd0);
    checkOutput("div_ignored_en", 32'(if_id_en), 32'd1);
`endif
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0);
      #3 checkOutput("div_busy", 32'(busy), 32'(DIV_EN));
    end
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    #3 checkOutput("div_release_en", 32'(if_id_en), 32'd1);
    checkOutput("div_release_busy", 32'(busy), 32'd0);
    idle(1'b1);
    #3 checkOutput("div_stall_count", 32'(stall_cycles), DIV_EN ? 32'd6 : 32'd2);

    // Reset in the second busy cycle aborts the freeze.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    #3 checkOutput("abort_reset_en", 32'(id_exe_en), 32'd0);
    idle(1'b1);
    #3 checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_if_id_en", 32'(if_id_en), 32'd1);
    checkOutput("abort_stall", 32'(stall_cycles), 32'd0);

    // Long load-use run to saturate the stall counter.
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    #3 checkOutput("sat_stall", 32'(stall_cycles), 32'd65535);
    idle(1'b1);
    #3 checkOutput("sat_hold", 32'(stall_cycles), 32'd65535);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
